// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and requester ids for the two-port RAM arbiter
package memarb_pkg;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} memarb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  function automatic memarb_state_t own_state(input logic id);
    return (id == REQ_AUX) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM-side signals of the arbiter
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req0, req1;
  logic                  lock0, lock1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic                  wr_enable0, wr_enable1;
  logic [DATA_WIDTH-1:0] wr_data0, wr_data1;
  logic                  ack0, ack1;
  logic                  rd_valid0, rd_valid1;
  logic [DATA_WIDTH-1:0] rd_data0, rd_data1;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr_enable;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  req0, req1, lock0, lock1, addr0, addr1,
    input  wr_enable0, wr_enable1, wr_data0, wr_data1, mem_rd_data,
    output ack0, ack1, rd_valid0, rd_valid1, rd_data0, rd_data1,
    output mem_addr, mem_wr_enable, mem_wr_data
  );

  modport master (
    output req0, req1, lock0, lock1, addr0, addr1,
    output wr_enable0, wr_enable1, wr_data0, wr_data1, mem_rd_data,
    input  ack0, ack1, rd_valid0, rd_valid1, rd_data0, rd_data1,
    input  mem_addr, mem_wr_enable, mem_wr_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter with lock for the single-port data RAM
// MEMARB_FIXED_PRIO_EN: requester 0 always wins conflicts in IDLE.
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  memarb_state_t state;
  logic          last;
  logic          grant0, grant1;
  logic          rd_valid0_q, rd_valid1_q;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      case (state)
        OWN0:    grant0 = bus.req0;
        OWN1:    grant1 = bus.req1;
        default: begin
          if (bus.req0 && bus.req1) begin
`ifdef MEMARB_FIXED_PRIO_EN
            grant0 = 1'b1;
`else
            grant0 = (last != REQ_CPU);
            grant1 = (last == REQ_CPU);
`endif
          end else begin
            grant0 = bus.req0;
            grant1 = bus.req1;
          end
        end
      endcase
    end
  end

  // Idle bus parks at address 0 with writes disabled.
  always_comb begin
    bus.ack0          = grant0;
    bus.ack1          = grant1;
    bus.mem_addr      = {ADDR_WIDTH{1'b0}};
    bus.mem_wr_enable = 1'b0;
    bus.mem_wr_data   = {DATA_WIDTH{1'b0}};
    if (grant0) begin
      bus.mem_addr      = bus.addr0;
      bus.mem_wr_enable = bus.wr_enable0;
      bus.mem_wr_data   = bus.wr_data0;
    end else if (grant1) begin
      bus.mem_addr      = bus.addr1;
      bus.mem_wr_enable = bus.wr_enable1;
      bus.mem_wr_data   = bus.wr_data1;
    end
  end

  // Masking with rst drops the strobe of a read acked just before reset.
  assign bus.rd_valid0 = rd_valid0_q & ~rst;
  assign bus.rd_valid1 = rd_valid1_q & ~rst;
  assign bus.rd_data0  = bus.mem_rd_data;
  assign bus.rd_data1  = bus.mem_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= REQ_AUX;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
    end else begin
      rd_valid0_q <= grant0 & ~bus.wr_enable0;
      rd_valid1_q <= grant1 & ~bus.wr_enable1;
      if (grant0) begin
        last  <= REQ_CPU;
        state <= bus.lock0 ? own_state(REQ_CPU) : IDLE;
      end else if (grant1) begin
        last  <= REQ_AUX;
        state <= bus.lock1 ? own_state(REQ_AUX) : IDLE;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter against a reference model
module tb_mem_arbiter;

`ifdef MEMARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM behaviour driven by whatever the DUT presents
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (bus.mem_wr_enable === 1'b1) ram[bus.mem_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= ram[bus.mem_addr];
  end

  // Stimulus state per requester
  logic        req [2];
  logic        lock [2];
  logic        we [2];
  logic [9:0]  addr [2];
  logic [31:0] wd [2];
  logic        acked [2];

  // Reference model: owner -1 means nobody holds the lock
  logic [31:0] ref_mem [1024];
  int          owner;
  int          last;
  logic        pend_rv [2];
  logic [31:0] pend_data;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set(input int n, input logic r, input logic l, input logic w,
                     input logic [9:0] a, input logic [31:0] d);
    req[n] = r; lock[n] = l; we[n] = w; addr[n] = a; wd[n] = d;
  endtask

  task automatic next_req(input int n);
    if (!req[n] || acked[n]) begin
      req[n]  = ($urandom_range(0, 3) != 0);
      lock[n] = ($urandom_range(0, 3) == 0);
      we[n]   = $urandom_range(0, 1) == 1;
      addr[n] = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      wd[n]   = $urandom;
    end
  endtask

  task automatic cycle(input logic r);
    int          g;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    rst            = r;
    bus.req0       = req[0];  bus.req1       = req[1];
    bus.lock0      = lock[0]; bus.lock1      = lock[1];
    bus.wr_enable0 = we[0];   bus.wr_enable1 = we[1];
    bus.addr0      = addr[0]; bus.addr1      = addr[1];
    bus.wr_data0   = wd[0];   bus.wr_data1   = wd[1];
    #2;
    g = -1;
    if (!r) begin
      if (owner >= 0)              g = req[owner] ? owner : -1;
      else if (req[0] && req[1])   g = FIXED ? 0 : 1 - last;
      else if (req[0])             g = 0;
      else if (req[1])             g = 1;
    end
    exp_we = 1'b0; exp_addr = 32'd0; exp_wd = 32'd0;
    if (g >= 0) begin
      exp_we = we[g]; exp_addr = {22'd0, addr[g]}; exp_wd = we[g] ? wd[g] : 32'd0;
    end
    chk("ack0", {31'd0, bus.ack0}, {31'd0, g == 0});
    chk("ack1", {31'd0, bus.ack1}, {31'd0, g == 1});
    chk("mem_wr_enable", {31'd0, bus.mem_wr_enable}, {31'd0, exp_we});
    chk("mem_addr", {22'd0, bus.mem_addr}, exp_addr);
    if (exp_we) chk("mem_wr_data", bus.mem_wr_data, exp_wd);
    chk("rd_valid0", {31'd0, bus.rd_valid0}, {31'd0, pend_rv[0] && !r});
    chk("rd_valid1", {31'd0, bus.rd_valid1}, {31'd0, pend_rv[1] && !r});
    if (pend_rv[0] && !r) chk("rd_data0", bus.rd_data0, pend_data);
    if (pend_rv[1] && !r) chk("rd_data1", bus.rd_data1, pend_data);
    @(posedge clk);
    pend_rv[0] = 1'b0;
    pend_rv[1] = 1'b0;
    if (r) begin
      owner = -1;
      last  = 1;
    end else if (g >= 0) begin
      last  = g;
      owner = lock[g] ? g : -1;
      if (we[g]) ref_mem[addr[g]] = wd[g];
      else begin
        pend_rv[g] = 1'b1;
        pend_data  = ref_mem[addr[g]];
      end
    end else begin
      owner = -1;
    end
    acked[0] = (g == 0);
    acked[1] = (g == 1);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    owner = -1; last = 1;
    pend_rv[0] = 1'b0; pend_rv[1] = 1'b0; pend_data = 32'd0;
    acked[0] = 1'b0; acked[1] = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end

    // Reset with both requesting, then first conflict
    set(0, 1, 0, 0, 10'h001, 0);
    set(1, 1, 0, 0, 10'h002, 0);
    cycle(1); cycle(1);
    repeat (6) cycle(0);

    // Write DEADBEEF to 5 via port 1, read it back on port 0
    set(0, 0, 0, 0, 10'h000, 0);
    set(1, 1, 0, 1, 10'h005, 32'hDEADBEEF);
    cycle(0);
    set(1, 0, 0, 0, 10'h000, 0);
    set(0, 1, 0, 0, 10'h005, 0);
    cycle(0);
    set(0, 0, 0, 0, 10'h000, 0);
    cycle(0);

    // Port 1 locked for three accesses while port 0 waits
    set(0, 1, 0, 0, 10'h005, 0);
    set(1, 1, 1, 0, 10'h007, 0);
    cycle(0); cycle(0); cycle(0);
    set(1, 0, 0, 0, 10'h000, 0);
    cycle(0); cycle(0); cycle(0);

    // Top address write then read
    set(0, 0, 0, 0, 10'h000, 0);
    set(1, 1, 0, 1, 10'h3FF, 32'h0000_00A5);
    cycle(0);
    set(1, 0, 0, 0, 10'h000, 0);
    set(0, 1, 0, 0, 10'h3FF, 0);
    cycle(0);
    set(0, 0, 0, 0, 10'h000, 0);
    cycle(0);

    // Reset right after an acked read, while port 1 holds a lock
    set(1, 1, 1, 0, 10'h3FF, 0);
    cycle(0);
    set(0, 1, 0, 0, 10'h005, 0);
    cycle(0);
    cycle(1);
    cycle(0); cycle(0);

    repeat (600) begin
      next_req(0);
      next_req(1);
      cycle($urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port data RAM (`Memory`). It lets the CPU data port and a second master (boot loader / debug / DMA) share the RAM's address, write-enable and write-data lines. It issues at most one access per cycle, selecting by round-robin, with an optional lock for atomic multi-cycle sequences. It sits between the requesters and `Memory` in the top level and returns read data with a registered valid strobe.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 10, RAM word-address width
- i_Clock  in  1  clock; all state changes on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Req0 / i_Req1  in  1  access request, held until acked
- i_Lock0 / i_Lock1  in  1  keep ownership after this access
- i_Addr0 / i_Addr1  in  ADDR_WIDTH  access address
- i_WrEnable0 / i_WrEnable1  in  1  1 = write, 0 = read
- i_WrData0 / i_WrData1  in  DATA_WIDTH  write data
- o_Ack0 / o_Ack1  out  1  access performed this cycle (combinational)
- o_RdValid0 / o_RdValid1  out  1  read data valid (registered)
- o_RdData0 / o_RdData1  out  DATA_WIDTH  read data, meaningful only when RdValid is high
- o_MemAddr  out  ADDR_WIDTH  to RAM
- o_MemWrEnable  out  1  to RAM
- o_MemWrData  out  DATA_WIDTH  to RAM
- i_MemRdData  in  DATA_WIDTH  from RAM; valid the cycle after the address is presented

## Operation
- State: IDLE, OWN0, OWN1. Also a priority pointer `Last` (id of the last granted requester).
- IDLE:
  - Only ReqN high → grant N.
  - Both high → grant the requester ≠ Last.
  - Neither → no grant; o_MemWrEnable = 0, o_MemAddr = 0.
- OWNn: only requester n is eligible.
  - i_Reqn high → grant n.
  - i_Reqn low → no grant; next state IDLE. The other requester waits ≥1 extra cycle.
- On a grant to n:
  - o_Ackn = 1; RAM lines driven from port n.
  - Last ← n.
  - Next state OWNn if i_Lockn = 1, else IDLE.
- Ungranted requester: Ack = 0. It must hold Req/Addr/WrEnable/WrData stable until acked.
- Read grant to n (WrEnable = 0): o_RdValidn = 1 next cycle; o_RdDatan = i_MemRdData. Write grant: no RdValid.
- o_RdData0/1 are both wired to i_MemRdData. Only the RdValid strobes are steered.
- No address or width arithmetic; buses pass through the mux unchanged.

## Timing
- Grant decision is combinational from state + requests. Ack and RAM lines are valid in the same cycle as Req.
- Throughput: one access per cycle. Back-to-back reads give RdValid on consecutive cycles.
- Read latency: 1 cycle, Ack → RdValid.
- With both requesting continuously and no locks, grants alternate 0,1,0,1…
- Reset (i_Reset = 1):
  - o_Ack0/1 = 0, o_MemWrEnable = 0.
  - State ← IDLE, Last ← 1 (so requester 0 wins the first conflict).
  - o_RdValid0/1 ← 0 on the next edge.
- Reset mid-lock: ownership is dropped. A read acked in the cycle before reset has its RdValid suppressed.
- Simultaneous Req0 and Req1 in OWNn: the non-owner is ignored regardless of Last.

## Configuration
- MEMARB_FIXED_PRIO_EN defined:
  - In IDLE, requester 0 always wins conflicts.
  - Last is still updated but ignored.
  - Lock behaviour unchanged.
- Not defined: round-robin as above.

## Structure
- Package `memarb_pkg`:
  - `typedef enum logic [1:0] {IDLE, OWN0, OWN1} memarb_state_t`
  - Requester id constants REQ_CPU = 0, REQ_AUX = 1.
- No sub-module. The grant logic, mux and RdValid registers are one compact module.

## Test plan
- Reset asserted with both Req high → Ack0 = Ack1 = 0, MemWrEnable = 0. First cycle after reset with both requesting → Ack0 = 1.
- Req0 read addr 0x005 after RAM[5] = 0xDEADBEEF → Ack0 same cycle; next cycle RdValid0 = 1, RdData0 = 0xDEADBEEF, RdValid1 = 0.
- Both request continuously for 6 cycles, no lock → grants 0,1,0,1,0,1. With MEMARB_FIXED_PRIO_EN → 0 for all 6 cycles, Ack1 never asserts.
- Req1 with Lock1 = 1 for 3 accesses while Req0 is held → Ack1 ×3, then an idle cycle when Req1 drops, then Ack0.
- Req1 write 0x0000_00A5 to 0x3FF, then Req0 read 0x3FF → RdData0 = 0x0000_00A5, no RdValid for the write.
- Reset pulsed one cycle after an acked read → no RdValid emitted, state IDLE.
